// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and parameter sanity helpers for the mMips hazard unit.
//   hz_state_t    : branch-shadow FSM state
//   pend_w_ok()   : pending counter is wide enough to hold MAX_INFLIGHT
//   reg_aw_ok()   : register address width covers NUM_REGS
package hazard_pkg;

  typedef enum logic [0:0] {
    HZ_RUN    = 1'b0,
    HZ_BRANCH = 1'b1
  } hz_state_t;

  function automatic bit pend_w_ok(int unsigned pend_w, int unsigned max_inflight);
    return (max_inflight >= 1) && ((1 << pend_w) > max_inflight);
  endfunction

  function automatic bit reg_aw_ok(int unsigned reg_aw, int unsigned num_regs);
    return (1 << reg_aw) >= num_regs;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Bundle between the ID-stage pipeline control and the hazard unit.
//   master : pipeline side, drives ID/WB/memory status, receives enables
//   slave  : hazard unit, consumes status, drives pc/ifid/bubble/pipe/imem enables
interface hazard_scoreboard_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
) ();
  logic              enable;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_rs_used;
  logic              id_rt_used;
  logic              id_wr_en;
  logic [REG_AW-1:0] id_wr_reg;
  logic              id_is_branch;
  logic              br_resolve;
  logic              wb_wr_en;
  logic [REG_AW-1:0] wb_wr_reg;
  logic              dmem_wait;
  logic              imem_wait;
  logic              pc_write;
  logic              ifid_write;
  logic              bubble;
  logic              pipe_en;
  logic              imem_en;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output enable, id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_wr_en, id_wr_reg,
           id_is_branch, br_resolve, wb_wr_en, wb_wr_reg, dmem_wait, imem_wait,
    input  pc_write, ifid_write, bubble, pipe_en, imem_en, bubble_cnt
  );

  modport slave (
    input  enable, id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_wr_en, id_wr_reg,
           id_is_branch, br_resolve, wb_wr_en, wb_wr_reg, dmem_wait, imem_wait,
    output pc_write, ifid_write, bubble, pipe_en, imem_en, bubble_cnt
  );
endinterface

// File: rtl/hazard_pend_ctr.sv
// Pending-write counter for one architectural register.
//   inc_i/dec_i : issue / retire of a write to this register
//   cnt_o       : outstanding writes
//   full_o      : cnt_o == MAX_INFLIGHT
//   nz_o        : at least one write outstanding
module hazard_pend_ctr #(
  parameter int unsigned PEND_W       = 2,
  parameter int unsigned MAX_INFLIGHT = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              inc_i,
  input  logic              dec_i,
  output logic [PEND_W-1:0] cnt_o,
  output logic              full_o,
  output logic              nz_o
);
  logic [PEND_W-1:0] cnt_q, cnt_d;

  assign cnt_o  = cnt_q;
  assign full_o = (cnt_q == PEND_W'(MAX_INFLIGHT));
  assign nz_o   = |cnt_q;

  // Simultaneous inc/dec cancel; underflow and overflow are dropped.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && !dec_i && !full_o) begin
      cnt_d = cnt_q + PEND_W'(1);
    end else if (dec_i && !inc_i && nz_o) begin
      cnt_d = cnt_q - PEND_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                   !(dec_i && !inc_i && !nz_o))
    else $error("retire of a register with no pending write");

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit beside the mMips ID stage. Tracks in-flight register writes, stalls ID on
// RAW/structural hazards, holds a branch shadow until EX resolves and freezes on memory waits.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of hazard_scoreboard_if (ID/WB/mem status in, enables out)
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned MAX_INFLIGHT = 3,
  parameter int unsigned PEND_W       = 2,
  parameter int unsigned ZERO_REG_HAZ = 0,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  hazard_scoreboard_if.slave  bus
);
  localparam int unsigned NumSlots = 1 << REG_AW;

  if (!pend_w_ok(PEND_W, MAX_INFLIGHT)) begin : g_bad_pend_w
    $error("PEND_W too narrow for MAX_INFLIGHT");
  end
  if (!reg_aw_ok(REG_AW, NUM_REGS)) begin : g_bad_reg_aw
    $error("REG_AW too narrow for NUM_REGS");
  end

  hz_state_t        state_q, state_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [NumSlots-1:0] nz_vec, full_vec;
  logic raw, strct, issue, retire;
  logic pc_write, ifid_write, bubble, pipe_en, imem_en, run_slot;

  // Untracked slots (r0 when excluded, addresses past NUM_REGS) read as never pending.
  for (genvar i = 0; i < NumSlots; i++) begin : g_reg
    if (i < NUM_REGS && (i != 0 || ZERO_REG_HAZ != 0)) begin : g_ctr
      logic              inc, dec;
      logic [PEND_W-1:0] cnt;
      assign inc = issue & bus.id_wr_en & (bus.id_wr_reg == REG_AW'(i));
      assign dec = retire & (bus.wb_wr_reg == REG_AW'(i));
      hazard_pend_ctr #(
        .PEND_W      (PEND_W),
        .MAX_INFLIGHT(MAX_INFLIGHT)
      ) u_ctr (
        .clk_i (clk),
        .rst_ni(rst_n),
        .inc_i (inc),
        .dec_i (dec),
        .cnt_o (cnt),
        .full_o(full_vec[i]),
        .nz_o  (nz_vec[i])
      );
      // The structural stall must keep issue away from a full counter.
      a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
                                      !(inc && !dec && cnt == PEND_W'(MAX_INFLIGHT)))
        else $error("issue to a full pending counter");
    end else begin : g_none
      assign nz_vec[i]   = 1'b0;
      assign full_vec[i] = 1'b0;
    end
  end

  assign raw   = bus.id_valid & ((bus.id_rs_used & nz_vec[bus.id_rs]) |
                                 (bus.id_rt_used & nz_vec[bus.id_rt]));
  assign strct = bus.id_valid & bus.id_wr_en & full_vec[bus.id_wr_reg];

  assign issue  = bus.id_valid & run_slot;
  assign retire = bus.wb_wr_en & pipe_en;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HZ_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; a resolve seen while frozen is ignored.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HZ_RUN:    if (issue && bus.id_is_branch) state_d = HZ_BRANCH;
      HZ_BRANCH: if (bus.enable && !bus.dmem_wait && !bus.imem_wait && bus.br_resolve) begin
        state_d = HZ_RUN;
      end
      default:   state_d = HZ_RUN;
    endcase
  end

  // Outputs, highest priority first
  always_comb begin
    pc_write   = 1'b0;
    ifid_write = 1'b0;
    bubble     = 1'b0;
    pipe_en    = 1'b0;
    imem_en    = 1'b0;
    run_slot   = 1'b0;
    if (!bus.enable) begin
      // everything held
    end else if (bus.dmem_wait || bus.imem_wait) begin
      imem_en = ~bus.dmem_wait;
    end else if (state_q == HZ_BRANCH) begin
      bubble   = 1'b1;
      pipe_en  = 1'b1;
      pc_write = bus.br_resolve;
      imem_en  = bus.br_resolve;
    end else if (raw || strct) begin
      bubble  = 1'b1;
      pipe_en = 1'b1;
    end else begin
      pipe_en    = 1'b1;
      ifid_write = 1'b1;
      run_slot   = 1'b1;
      pc_write   = ~(bus.id_valid & bus.id_is_branch);
      imem_en    = ~(bus.id_valid & bus.id_is_branch);
    end
  end

  assign bubble_cnt_d = (bubble && !(&bubble_cnt_q)) ? bubble_cnt_q + CNT_W'(1) : bubble_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign bus.pc_write   = pc_write;
  assign bus.ifid_write = ifid_write;
  assign bus.bubble     = bubble;
  assign bus.pipe_en    = pipe_en;
  assign bus.imem_en    = imem_en;
  assign bus.bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard. Output vector order:
// {pc_write, ifid_write, bubble, pipe_en, imem_en}. bubble_cnt is 4 bits here so that
// saturation is reachable.
module tb_hazard_scoreboard;
  localparam int unsigned CntW = 4;
  localparam logic [4:0] ORun   = 5'b11011;
  localparam logic [4:0] OStall = 5'b00110;
  localparam logic [4:0] OBrIss = 5'b01010;
  localparam logic [4:0] ORslv  = 5'b10111;
  localparam logic [4:0] OFroz  = 5'b00000;
  localparam logic [4:0] OIWait = 5'b00001;

  logic clk = 1'b0;
  logic rst_n;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  hazard_scoreboard_if #(.REG_AW(5), .CNT_W(CntW)) bus ();

  hazard_scoreboard #(
    .NUM_REGS(32), .REG_AW(5), .MAX_INFLIGHT(3), .PEND_W(2), .ZERO_REG_HAZ(0), .CNT_W(CntW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [4:0] exp);
    #1;
    check_val(tag, 32'({bus.pc_write, bus.ifid_write, bus.bubble, bus.pipe_en, bus.imem_en}),
              32'(exp));
  endtask

  task automatic chk_cnt(input string tag, input int unsigned exp);
    check_val(tag, 32'(bus.bubble_cnt), 32'(exp));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.enable = 1'b1;  bus.id_valid = 1'b0;  bus.id_rs = '0;  bus.id_rt = '0;
    bus.id_rs_used = 1'b0;  bus.id_rt_used = 1'b0;  bus.id_wr_en = 1'b0;  bus.id_wr_reg = '0;
    bus.id_is_branch = 1'b0;  bus.br_resolve = 1'b0;  bus.wb_wr_en = 1'b0;  bus.wb_wr_reg = '0;
    bus.dmem_wait = 1'b0;  bus.imem_wait = 1'b0;
  endtask

  task automatic id_in(input logic v, input logic [4:0] rs, input logic rsu, input logic [4:0] rt,
                       input logic rtu, input logic we, input logic [4:0] wr, input logic br);
    bus.id_valid = v;  bus.id_rs = rs;  bus.id_rs_used = rsu;  bus.id_rt = rt;
    bus.id_rt_used = rtu;  bus.id_wr_en = we;  bus.id_wr_reg = wr;  bus.id_is_branch = br;
  endtask

  task automatic wb_in(input logic en, input logic [4:0] r);
    bus.wb_wr_en = en;
    bus.wb_wr_reg = r;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    chk_out("rst_outs", ORun);
    chk_cnt("rst_cnt", 0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // RAW on r5
    id_in(1, 0, 0, 0, 0, 1, 5, 0);  chk_out("raw_issue", ORun);  step();
    id_in(1, 5, 1, 0, 0, 0, 0, 0);  chk_out("raw_stall0", OStall);  step();
    chk_out("raw_stall1", OStall);  chk_cnt("raw_cnt1", 1);  step();
    wb_in(1, 5);  chk_out("raw_retire", OStall);  step();
    wb_in(0, 0);  chk_out("raw_go", ORun);  chk_cnt("raw_cnt3", 3);  step();

    // Structural on r7
    for (int k = 0; k < 3; k++) begin
      id_in(1, 0, 0, 0, 0, 1, 7, 0);  chk_out("st_issue", ORun);  step();
    end
    chk_out("st_full", OStall);  step();
    wb_in(1, 7);  chk_out("st_retire", OStall);  step();
    wb_in(0, 0);  chk_out("st_go", ORun);  step();
    idle();
    for (int k = 0; k < 3; k++) begin
      wb_in(1, 7);  chk_out("st_drain", ORun);  step();
    end
    wb_in(0, 0);

    // Branch shadow, resolve ignored while frozen
    id_in(1, 0, 0, 0, 0, 0, 0, 1);  chk_out("br_issue", OBrIss);  step();
    idle();  chk_out("br_shadow0", OStall);  step();
    bus.dmem_wait = 1'b1;  bus.br_resolve = 1'b1;  chk_out("br_wait", OFroz);  step();
    idle();  chk_out("br_shadow1", OStall);  step();
    bus.br_resolve = 1'b1;  chk_out("br_resolve", ORslv);  step();
    idle();  chk_out("br_run", ORun);  chk_cnt("br_cnt", 8);  step();

    // Memory waits and disable during a RAW stall
    id_in(1, 0, 0, 0, 0, 1, 5, 0);  chk_out("mw_issue", ORun);  step();
    id_in(1, 5, 1, 0, 0, 0, 0, 0);  chk_out("mw_stall", OStall);  step();
    bus.dmem_wait = 1'b1;  chk_out("mw_dmem", OFroz);  step();
    bus.dmem_wait = 1'b0;  bus.imem_wait = 1'b1;  wb_in(1, 5);
    chk_out("mw_imem", OIWait);  step();
    bus.imem_wait = 1'b0;  bus.enable = 1'b0;  chk_out("mw_disable", OFroz);  step();
    bus.enable = 1'b1;  wb_in(0, 0);  chk_out("mw_resume", OStall);  step();
    wb_in(1, 5);  chk_out("mw_retire", OStall);  step();
    wb_in(0, 0);  chk_out("mw_go", ORun);  step();
    idle();

    // Same-cycle issue and retire of r9
    id_in(1, 0, 0, 0, 0, 1, 9, 0);  chk_out("r9_issue", ORun);  step();
    wb_in(1, 9);  chk_out("r9_both", ORun);  step();
    wb_in(0, 0);  id_in(1, 9, 1, 0, 0, 0, 0, 0);  chk_out("r9_still1", OStall);  step();
    wb_in(1, 9);  chk_out("r9_retire", OStall);  step();
    wb_in(0, 0);  chk_out("r9_go", ORun);  chk_cnt("r9_cnt", 13);  step();

    // r0 is never pending
    id_in(1, 0, 0, 0, 0, 1, 0, 0);  chk_out("r0_write", ORun);  step();
    id_in(1, 0, 1, 0, 1, 0, 0, 0);  chk_out("r0_read", ORun);  step();

    // Reset mid-operation: pend[3]=2, in BRANCH, counter saturating
    id_in(1, 0, 0, 0, 0, 1, 3, 0);  chk_out("rs_w3a", ORun);  step();
    chk_out("rs_w3b", ORun);  step();
    id_in(1, 0, 0, 0, 0, 0, 0, 1);  chk_out("rs_br", OBrIss);  step();
    idle();  chk_out("rs_shadow", OStall);  chk_cnt("rs_cnt13", 13);  step();
    chk_cnt("rs_cnt14", 14);  step();
    chk_cnt("rs_cnt15", 15);  step();
    chk_out("rs_shadow_sat", OStall);  chk_cnt("rs_cnt_sat", 15);
    rst_n = 1'b0;
    chk_out("rs_async", ORun);  chk_cnt("rs_cnt0", 0);
    @(negedge clk) rst_n = 1'b1;
    id_in(1, 3, 1, 3, 1, 0, 0, 0);  chk_out("rs_r3_clear", ORun);
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
